// File: rtl/product_unloader_if.sv
// rtl/product_unloader_if.sv - product capture and host word handshake bundle
//
// Purpose: groups the multiplier-side product handshake and the host-side
// word stream handshake of product_unloader.
// Signals:
//   prod_valid / prod_data / prod_ready : product offered by the multiplier
//   word_valid / word_data / word_last / word_ready : word stream to host
// Modports:
//   master : the environment (multiplier + host) around the unloader
//   slave  : the unloader itself
interface product_unloader_if #(
  parameter int WORD_W = 16
);
  logic                  prod_valid;
  logic [2*WORD_W-1:0]   prod_data;
  logic                  prod_ready;
  logic                  word_valid;
  logic [WORD_W-1:0]     word_data;
  logic                  word_last;
  logic                  word_ready;

  modport master (
    output prod_valid, prod_data, word_ready,
    input  prod_ready, word_valid, word_data, word_last
  );

  modport slave (
    input  prod_valid, prod_data, word_ready,
    output prod_ready, word_valid, word_data, word_last
  );
endinterface

// File: rtl/product_unloader.sv
// rtl/product_unloader.sv - streams a 2*WORD_W product to the host as two words
//
// Purpose: captures one finished product from the multiplier, presents it to
// the host bus as two WORD_W words with a valid/ready handshake, pulses done
// one cycle after the last word transfers and counts delivered products.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   bus        : product_unloader_if.slave (product in, word stream out)
//   busy       : a product is held and not yet fully delivered
//   done       : one-cycle pulse after the final word transfers
//   prod_count : delivered products, wraps modulo 256
// Build option: PRODUCT_UNLOADER_HI_FIRST_EN sends the high half first.
module product_unloader #(
  parameter int WORD_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  product_unloader_if.slave      bus,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             prod_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [2*WORD_W-1:0] hold;
  logic                capture;
  logic                final_xfer;
  logic [WORD_W-1:0]   first_word, second_word;

`ifdef PRODUCT_UNLOADER_HI_FIRST_EN
  assign first_word  = hold[2*WORD_W-1:WORD_W];
  assign second_word = hold[WORD_W-1:0];
`else
  assign first_word  = hold[WORD_W-1:0];
  assign second_word = hold[2*WORD_W-1:WORD_W];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      done       <= 1'b0;
      prod_count <= 8'd0;
    end else begin
      state <= state_next;
      // Holding register only loads on the capture edge; it stays frozen
      // through both sends and any stall.
      if (capture) begin
        hold <= bus.prod_data;
      end
      done <= final_xfer;
      if (final_xfer) begin
        prod_count <= prod_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    capture        = 1'b0;
    final_xfer     = 1'b0;
    bus.prod_ready = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_last  = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        bus.prod_ready = 1'b1;
        busy           = 1'b0;
        if (bus.prod_valid) begin
          capture    = 1'b1;
          state_next = SEND_FIRST;
        end
      end
      SEND_FIRST: begin
        bus.word_valid = 1'b1;
        bus.word_data  = first_word;
        if (bus.word_ready) begin
          state_next = SEND_SECOND;
        end
      end
      SEND_SECOND: begin
        bus.word_valid = 1'b1;
        bus.word_data  = second_word;
        bus.word_last  = 1'b1;
        if (bus.word_ready) begin
          final_xfer = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_product_unloader.sv
// tb/tb_product_unloader.sv - directed self-checking bench for product_unloader
module tb_product_unloader;

  logic       clk;
  logic       reset;
  logic       busy;
  logic       done;
  logic [7:0] prod_count;
  int         vectors;
  int         miscompares;

  product_unloader_if #(.WORD_W(16)) bus ();

  product_unloader #(.WORD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .prod_count (prod_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_first(input logic [31:0] p);
`ifdef PRODUCT_UNLOADER_HI_FIRST_EN
    return p[31:16];
`else
    return p[15:0];
`endif
  endfunction

  function automatic logic [15:0] exp_second(input logic [31:0] p);
`ifdef PRODUCT_UNLOADER_HI_FIRST_EN
    return p[15:0];
`else
    return p[31:16];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input logic last);
    check({tag, " valid"}, {31'd0, bus.word_valid}, 32'd1);
    check({tag, " data"},  {16'd0, bus.word_data},  {16'd0, w});
    check({tag, " last"},  {31'd0, bus.word_last},  {31'd0, last});
    check({tag, " busy"},  {31'd0, busy},           32'd1);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod_data  = 32'd0;
    bus.word_ready = 1'b0;

    // Reset state
    tick();
    check("rst prod_ready", {31'd0, bus.prod_ready}, 32'd1);
    check("rst word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst word_data",  {16'd0, bus.word_data},  32'd0);
    check("rst word_last",  {31'd0, bus.word_last},  32'd0);
    check("rst busy",       {31'd0, busy},           32'd0);
    check("rst done",       {31'd0, done},           32'd0);
    check("rst count",      {24'd0, prod_count},     32'd0);
    reset = 1'b0;
    tick();

    // Basic transfer
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'h1234_ABCD;
    bus.word_ready = 1'b1;
    tick();
    bus.prod_valid = 1'b0;
    check("basic prod_ready", {31'd0, bus.prod_ready}, 32'd0);
    check_word("basic w1", exp_first(32'h1234_ABCD), 1'b0);
    check("basic done early", {31'd0, done}, 32'd0);
    tick();
    check_word("basic w2", exp_second(32'h1234_ABCD), 1'b1);
    tick();
    check("basic done",       {31'd0, done},           32'd1);
    check("basic idle valid", {31'd0, bus.word_valid}, 32'd0);
    check("basic prod_ready2",{31'd0, bus.prod_ready}, 32'd1);
    check("basic busy",       {31'd0, busy},           32'd0);
    check("basic count",      {24'd0, prod_count},     32'd1);
    tick();
    check("basic done drop",  {31'd0, done},           32'd0);

    // Stall in SEND_FIRST for 4 cycles
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'hDEAD_BEEF;
    bus.word_ready = 1'b0;
    tick();
    bus.prod_valid = 1'b0;
    bus.prod_data  = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      check_word("stall w1", exp_first(32'hDEAD_BEEF), 1'b0);
      tick();
    end
    check_word("stall w1 end", exp_first(32'hDEAD_BEEF), 1'b0);
    bus.word_ready = 1'b1;
    tick();
    check_word("stall w2", exp_second(32'hDEAD_BEEF), 1'b1);
    tick();
    check("stall done",  {31'd0, done},       32'd1);
    check("stall count", {24'd0, prod_count}, 32'd2);
    tick();

    // Offer a product during SEND_SECOND; it must be ignored
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'h5555_AAAA;
    tick();
    bus.prod_valid = 1'b0;
    check_word("busy w1", exp_first(32'h5555_AAAA), 1'b0);
    tick();
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'h0000_FFFF;
    check("busy prod_ready", {31'd0, bus.prod_ready}, 32'd0);
    check_word("busy w2", exp_second(32'h5555_AAAA), 1'b1);
    tick();
    bus.prod_valid = 1'b0;
    check("busy done",  {31'd0, done},           32'd1);
    check("busy count", {24'd0, prod_count},     32'd3);
    check("busy idle",  {31'd0, bus.word_valid}, 32'd0);
    tick();
    check("busy not captured", {31'd0, bus.word_valid}, 32'd0);
    check("busy no done",      {31'd0, done},           32'd0);

    // Back-to-back with prod_valid held high
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'h0001_0002;
    tick();
    bus.prod_data  = 32'h0003_0004;
    check_word("b2b p1 w1", exp_first(32'h0001_0002), 1'b0);
    tick();
    check_word("b2b p1 w2", exp_second(32'h0001_0002), 1'b1);
    tick();
    check("b2b done1",   {31'd0, done},           32'd1);
    check("b2b ready",   {31'd0, bus.prod_ready}, 32'd1);
    check("b2b count1",  {24'd0, prod_count},     32'd4);
    tick();
    bus.prod_valid = 1'b0;
    check("b2b done gap", {31'd0, done}, 32'd0);
    check_word("b2b p2 w1", exp_first(32'h0003_0004), 1'b0);
    tick();
    check_word("b2b p2 w2", exp_second(32'h0003_0004), 1'b1);
    tick();
    check("b2b done2",  {31'd0, done},       32'd1);
    check("b2b count2", {24'd0, prod_count}, 32'd5);
    tick();

    // Deliver products until the counter wraps
    for (int i = 0; i < 250; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod_data  = 32'h0100_0000 + i;
      tick();
      bus.prod_valid = 1'b0;
      tick();
      tick();
      tick();
    end
    check("wrap 255", {24'd0, prod_count}, 32'd255);
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'hCAFE_0001;
    tick();
    bus.prod_valid = 1'b0;
    tick();
    tick();
    check("wrap done", {31'd0, done},       32'd1);
    check("wrap 0",    {24'd0, prod_count}, 32'd0);
    tick();

    // Reset while in SEND_FIRST
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'h7777_8888;
    bus.word_ready = 1'b0;
    tick();
    bus.prod_valid = 1'b0;
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid-rst word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("mid-rst word_data",  {16'd0, bus.word_data},  32'd0);
    check("mid-rst busy",       {31'd0, busy},           32'd0);
    check("mid-rst prod_ready", {31'd0, bus.prod_ready}, 32'd1);
    check("mid-rst count",      {24'd0, prod_count},     32'd0);
    tick();
    reset = 1'b0;
    bus.word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-rst no done",  {31'd0, done},           32'd0);
      check("post-rst idle",     {31'd0, bus.word_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
